// File: rtl/shift_rows_serial.sv
// Byte-serial forward AES ShiftRows engine.
// Takes in a 16-byte state over a valid/ready stream. Once the whole
// block is buffered, it sends the bytes back out in ShiftRows order.
// Output byte (r,c) is taken from input byte (r,(c+r) mod 4).
// Optional build macro SHIFT_ROWS_SERIAL_PINGPONG_EN:
//   - two buffers, so loading one block overlaps draining the previous one.
//   - without it, a single buffer alternates between LOAD and DRAIN.
module shift_rows_serial #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] blk_cnt
);

    // Source index in the buffered block for output position k.
    // k = 4c + r; the source is 4*((c+r) mod 4) + r. The 2-bit add wraps mod 4.
    function automatic logic [3:0] src_idx(input logic [3:0] k);
        logic [1:0] col;
        col = k[3:2] + k[1:0];
        return {col, k[1:0]};
    endfunction

    logic [3:0]       wr_idx_q, wr_idx_d;
    logic [3:0]       rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             in_fire, out_fire;

    // clear wins over any transfer presented in the same cycle.
    assign in_fire  = in_valid && in_ready && !clear;
    assign out_fire = out_valid && out_ready && !clear;
    assign blk_cnt  = blk_cnt_q;

`ifdef SHIFT_ROWS_SERIAL_PINGPONG_EN
    logic [7:0] buf_q [2][16];
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] full_q, full_d;

    assign in_ready  = !full_q[wr_sel_q];
    assign out_valid = full_q[rd_sel_q];
    assign out_last  = out_valid && (rd_idx_q == 4'd15);
    assign out_data  = out_valid ? buf_q[rd_sel_q][src_idx(rd_idx_q)] : 8'h00;

    // Buffer data path: no reset; contents are qualified by the full flags.
    always_ff @(posedge clk) begin
        if (in_fire) buf_q[wr_sel_q][wr_idx_q] <= in_data;
    end

    // Next-state logic for the pointers, buffer selects and full flags.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        full_d    = full_q;
        blk_cnt_d = blk_cnt_q;
        // Release the drained buffer first. Writing and reading the same
        // buffer in one cycle is impossible: in_ready needs it empty and
        // out_valid needs it full. So the two updates never collide.
        if (out_fire) begin
            rd_idx_d = rd_idx_q + 4'd1;
            if (rd_idx_q == 4'd15) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                blk_cnt_d        = blk_cnt_q + CNT_W'(1);
            end
        end
        if (in_fire) begin
            wr_idx_d = wr_idx_q + 4'd1;
            if (wr_idx_q == 4'd15) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end
        end
        if (clear) begin
            wr_idx_d = 4'd0;
            rd_idx_d = 4'd0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
            full_d   = 2'b00;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q  <= 4'd0;
            rd_idx_q  <= 4'd0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            full_q    <= 2'b00;
            blk_cnt_q <= '0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            full_q    <= full_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end
`else
    typedef enum logic {LOAD, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] buf_q [16];

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (rd_idx_q == 4'd15);
    assign out_data  = out_valid ? buf_q[src_idx(rd_idx_q)] : 8'h00;

    // Buffer data path: no reset; only read while in DRAIN.
    always_ff @(posedge clk) begin
        if (in_fire) buf_q[wr_idx_q] <= in_data;
    end

    // LOAD/DRAIN next-state logic and pointer updates.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        blk_cnt_d = blk_cnt_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    wr_idx_d = wr_idx_q + 4'd1;
                    if (wr_idx_q == 4'd15) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    rd_idx_d = rd_idx_q + 4'd1;
                    if (rd_idx_q == 4'd15) begin
                        blk_cnt_d = blk_cnt_q + CNT_W'(1);
                        state_d   = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        if (clear) begin
            state_d  = LOAD;
            wr_idx_d = 4'd0;
            rd_idx_d = 4'd0;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            wr_idx_q  <= 4'd0;
            rd_idx_q  <= 4'd0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end
`endif

endmodule
